pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter generator that succeeds the plain `pc` register.
- Holds the fetch PC and selects the next PC each cycle from these sources: reset vector, trap vector, back-end redirect, front-end jump/call, return-address stack (RAS) pop, or sequential increment.
- Sits between the fetch stage and the branch/execute stage.
- Adds stall, alignment checking and a circular RAS of configurable depth.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0100, PC on trap, misalignment or RAS underflow.
- INC, 4, sequential increment; must be a power of two.
- RAS_DEPTH, 4, number of RAS entries; must be at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC; blocks jump, ret and sequential updates.
- trap  in  1  exception request.
- redirect_valid  in  1  back-end branch or mispredict redirect.
- redirect_pc  in  XLEN  redirect target.
- jump_valid  in  1  front-end jump.
- jump_target  in  XLEN  jump target.
- jump_is_call  in  1  qualifies jump_valid; push the return address.
- ret_valid  in  1  return; pop the RAS.
- pc  out  XLEN  current fetch PC, registered.
- pc_next  out  XLEN  combinational next-PC value.
- misalign_err  out  1  registered one-cycle pulse.
- ret_underflow  out  1  registered one-cycle pulse.
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - pc=RESET_VECTOR; ras_count=0; RAS pointer=0.
  - misalign_err=0; ret_underflow=0.
  - rst overrides every other input. Asserting rst mid-operation discards all pending RAS content.
- Next-PC priority, highest first, evaluated each cycle:
  1. trap: pc_next=TRAP_VECTOR. RAS unchanged.
  2. redirect_valid: pc_next=redirect_pc. Overrides stall. RAS unchanged.
  3. stall: pc_next=pc. jump, ret and RAS activity are ignored.
  4. jump_valid: pc_next=jump_target. If jump_is_call, push pc+INC.
  5. ret_valid with ras_count>0: pc_next=top of RAS; pop.
  6. ret_valid with ras_count=0: pc_next=TRAP_VECTOR; ret_underflow=1 next cycle.
  7. Otherwise: pc_next=pc+INC, wrapping modulo 2^XLEN (e.g. 32'hFFFF_FFFC -> 32'h0000_0000).
- Simultaneous jump_valid and ret_valid: the jump wins and the ret is dropped, with no pop.
- Alignment:
  - A selected redirect_pc or jump_target whose low log2(INC) bits are nonzero is misaligned.
  - On misalignment: pc_next=TRAP_VECTOR; misalign_err=1 on the following cycle; no push.
- Latency: pc updates one cycle after the selecting inputs are sampled. pc_next is valid in the same cycle as its inputs.
- RAS organisation:
  - Circular buffer with a top pointer.
  - Push writes at the pointer and advances it; ras_count saturates at RAS_DEPTH.
  - When full, a push silently overwrites the oldest entry.
  - Pop retreats the pointer and decrements ras_count.
  - Pointers wrap modulo RAS_DEPTH.
- Pulses: misalign_err and ret_underflow are high for exactly one cycle per event and are cleared the following cycle unless the event repeats.
- Outputs are deterministic under all input combinations; no X-propagation from unused targets.

Test Plan:
1. Reset then free-run: rst=1 for 1 cycle, then idle 4 cycles -> pc = 0x0, 0x4, 0x8, 0xC, 0x10; ras_count=0.
2. Stall versus redirect: at pc=0x10, stall=1 for 2 cycles -> pc holds 0x10. Then stall=1 with redirect_valid=1, redirect_pc=0x200 -> pc=0x200 next cycle.
3. Call/return:
   - At pc=0x40, jump_valid=1, jump_is_call=1, jump_target=0x800 -> pc=0x800, ras_count=1.
   - Idle 2 cycles, then ret_valid=1 -> pc=0x44, ras_count=0.
4. RAS overflow with RAS_DEPTH=4:
   - 5 nested calls from pcs 0x0, 0x100, 0x200, 0x300, 0x400 (each targeting the next) -> ras_count saturates at 4.
   - 5 rets return to 0x404, 0x304, 0x204, 0x104.
   - The 5th ret gives pc=0x100 (TRAP_VECTOR) with ret_underflow pulsed for 1 cycle.
5. Misalignment and trap:
   - redirect_pc=0x202 -> pc=0x100, misalign_err=1 for one cycle, RAS unchanged.
   - trap=1 together with jump_valid=1 -> pc=0x100, no push.
6. Wrap-around and mid-operation reset:
   - Redirect to 0xFFFF_FFFC, idle 1 cycle -> pc=0x0.
   - With ras_count=2, assert rst -> pc=0x0, ras_count=0; a subsequent ret gives ret_underflow=1.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch program-counter generator with prioritised next-PC selection,
// stall, target alignment checking and a circular return-address stack.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             trap,
    input  logic                             redirect_valid,
    input  logic [XLEN-1:0]                  redirect_pc,
    input  logic                             jump_valid,
    input  logic [XLEN-1:0]                  jump_target,
    input  logic                             jump_is_call,
    input  logic                             ret_valid,
    output logic [XLEN-1:0]                  pc,
    output logic [XLEN-1:0]                  pc_next,
    output logic                             misalign_err,
    output logic                             ret_underflow,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

    localparam int unsigned     CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam int unsigned     PTR_W      = $clog2(RAS_DEPTH);
    localparam logic [XLEN-1:0] INC_VAL    = XLEN'(INC);
    // INC is a power of two, so its low bits form the alignment mask.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    logic [XLEN-1:0]  pc_q;
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             misalign_q;
    logic             underflow_q;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];

    logic [XLEN-1:0]  seq_pc;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [XLEN-1:0]  ras_top;
    logic             ras_full;
    logic             ras_empty;

    logic [XLEN-1:0]  pc_next_c;
    logic             push_c;
    logic             pop_c;
    logic             misalign_c;
    logic             underflow_c;

    assign seq_pc    = pc_q + INC_VAL;
    // ptr_q points at the next free slot; wrap explicitly so any depth works.
    assign ptr_inc   = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    assign ptr_dec   = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
    assign ras_top   = ras_q[ptr_dec];
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_empty = (cnt_q == '0);

    // Next-PC selection, highest priority first.
    always_comb begin
        pc_next_c   = seq_pc;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        misalign_c  = 1'b0;
        underflow_c = 1'b0;
        if (rst) begin
            pc_next_c = RESET_VECTOR;
        end else if (trap) begin
            pc_next_c = TRAP_VECTOR;
        end else if (redirect_valid) begin
            if ((redirect_pc & ALIGN_MASK) != '0) begin
                pc_next_c  = TRAP_VECTOR;
                misalign_c = 1'b1;
            end else begin
                pc_next_c = redirect_pc;
            end
        end else if (stall) begin
            pc_next_c = pc_q;
        end else if (jump_valid) begin
            // A jump beats a simultaneous ret; the ret is simply dropped.
            if ((jump_target & ALIGN_MASK) != '0) begin
                pc_next_c  = TRAP_VECTOR;
                misalign_c = 1'b1;
            end else begin
                pc_next_c = jump_target;
                push_c    = jump_is_call;
            end
        end else if (ret_valid) begin
            if (!ras_empty) begin
                pc_next_c = ras_top;
                pop_c     = 1'b1;
            end else begin
                pc_next_c   = TRAP_VECTOR;
                underflow_c = 1'b1;
            end
        end
    end

    // PC, RAS pointer/count and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            ptr_q       <= '0;
            cnt_q       <= '0;
            misalign_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_next_c;
            misalign_q  <= misalign_c;
            underflow_q <= underflow_c;
            if (push_c) begin
                ptr_q <= ptr_inc;
                // When full the push overwrites the oldest entry; count stays.
                if (!ras_full) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (pop_c) begin
                ptr_q <= ptr_dec;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // RAS storage; cleared on reset so no stale value is ever visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else if (push_c) begin
            ras_q[ptr_q] <= seq_pc;
        end
    end

    assign pc            = pc_q;
    assign pc_next       = pc_next_c;
    assign misalign_err  = misalign_q;
    assign ret_underflow = underflow_q;
    assign ras_count     = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit; a queue-based reference model feeds
// expected post-edge state to a monitor that compares it every cycle.
module tb_pc_unit;

    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, stall, trap, redirect_valid, jump_valid, jump_is_call, ret_valid;
    logic [31:0] redirect_pc, jump_target;
    logic [31:0] pc, pc_next;
    logic        misalign_err, ret_underflow;
    logic [2:0]  ras_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        mis;
        logic        und;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          checks = 0;
    int          errors = 0;

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INC(4), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .jump_valid(jump_valid), .jump_target(jump_target), .jump_is_call(jump_is_call),
        .ret_valid(ret_valid), .pc(pc), .pc_next(pc_next),
        .misalign_err(misalign_err), .ret_underflow(ret_underflow), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: RAS as a bounded list, newest at the back.
    task automatic model(input bit r, s, t, rv, input logic [31:0] rpc, input bit jv,
                         input logic [31:0] jt, input bit jc, input bit rt, output exp_t e);
        logic [31:0] nxt;
        bit mis, und;
        mis = 0;
        und = 0;
        nxt = m_pc + 32'd4;
        if (r) begin
            nxt = RV;
            m_ras.delete();
        end else if (t) begin
            nxt = TV;
        end else if (rv) begin
            if (rpc % 4 != 0) begin nxt = TV; mis = 1; end
            else nxt = rpc;
        end else if (s) begin
            nxt = m_pc;
        end else if (jv) begin
            if (jt % 4 != 0) begin
                nxt = TV;
                mis = 1;
            end else begin
                nxt = jt;
                if (jc) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end
        end else if (rt) begin
            if (m_ras.size() > 0) nxt = m_ras.pop_back();
            else begin nxt = TV; und = 1; end
        end
        m_pc  = nxt;
        e.pc  = nxt;
        e.cnt = 3'(m_ras.size());
        e.mis = mis;
        e.und = und;
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected result.
    task automatic cyc(input bit r, s, t, rv, input logic [31:0] rpc, input bit jv,
                       input logic [31:0] jt, input bit jc, input bit rt);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; trap = t; redirect_valid = rv; redirect_pc = rpc;
        jump_valid = jv; jump_target = jt; jump_is_call = jc; ret_valid = rt;
        model(r, s, t, rv, rpc, jv, jt, jc, rt, e);
        #1;
        check("pc_next", pc_next, e.pc);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic redir(input logic [31:0] a);
        cyc(0, 0, 0, 1, a, 0, 0, 0, 0);
    endtask
    task automatic call(input logic [31:0] a);
        cyc(0, 0, 0, 0, 0, 1, a, 1, 0);
    endtask
    task automatic ret1();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Directed spot check of the state just after the edge following the last cyc.
    task automatic at_state(input string name, input logic [31:0] p, input int c,
                            input bit mis, input bit und);
        @(posedge clk);
        #2;
        check({name, "_pc"}, pc, p);
        check({name, "_cnt"}, 32'(ras_count), 32'(c));
        check({name, "_mis"}, 32'(misalign_err), 32'(mis));
        check({name, "_und"}, 32'(ret_underflow), 32'(und));
    endtask

    // Monitor: the DUT presents new state after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_pc", pc, e.pc);
                check("sb_ras_count", 32'(ras_count), 32'(e.cnt));
                check("sb_misalign", 32'(misalign_err), 32'(e.mis));
                check("sb_underflow", 32'(ret_underflow), 32'(e.und));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_pc = 32'h0;
        rst = 1; stall = 0; trap = 0; redirect_valid = 0; redirect_pc = 0;
        jump_valid = 0; jump_target = 0; jump_is_call = 0; ret_valid = 0;

        // Reset then free-run.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        at_state("reset", 32'h0, 0, 0, 0);
        idle(4);
        at_state("freerun", 32'h10, 0, 0, 0);

        // Stall holds, redirect beats stall.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 32'h900, 1, 1);
        at_state("stall", 32'h10, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h200, 0, 0, 0, 0);
        at_state("stall_redir", 32'h200, 0, 0, 0);

        // Call/return.
        redir(32'h40);
        call(32'h800);
        at_state("call", 32'h800, 1, 0, 0);
        idle(2);
        ret1();
        at_state("ret", 32'h44, 0, 0, 0);

        // RAS overflow and underflow.
        redir(32'h0);
        call(32'h100); call(32'h200); call(32'h300); call(32'h400); call(32'h500);
        at_state("ras_full", 32'h500, 4, 0, 0);
        ret1(); at_state("ret1", 32'h404, 3, 0, 0);
        ret1(); at_state("ret2", 32'h304, 2, 0, 0);
        ret1(); at_state("ret3", 32'h204, 1, 0, 0);
        ret1(); at_state("ret4", 32'h104, 0, 0, 0);
        ret1(); at_state("ret5", TV, 0, 0, 1);
        idle(1); at_state("und_clear", TV + 32'h4, 0, 0, 0);

        // Misalignment and trap.
        call(32'h600);
        redir(32'h202);
        at_state("misalign", TV, 1, 1, 0);
        idle(1);
        at_state("mis_clear", TV + 32'h4, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h702, 1, 0);
        at_state("jmp_misalign", TV, 1, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 32'h900, 1, 0);
        at_state("trap", TV, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'hA00, 0, 1);
        at_state("jump_beats_ret", 32'hA00, 1, 0, 0);

        // Wrap-around and mid-operation reset.
        redir(32'hFFFF_FFFC);
        idle(1);
        at_state("wrap", 32'h0, 1, 0, 0);
        call(32'h40);
        at_state("two_calls", 32'h40, 2, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'h80, 1, 1);
        at_state("mid_reset", 32'h0, 0, 0, 0);
        ret1();
        at_state("reset_underflow", TV, 0, 0, 1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            bit          r, s, t, rv, jv, jc, rt;
            logic [31:0] a, b;
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 99) < 15);
            t  = ($urandom_range(0, 99) < 3);
            rv = ($urandom_range(0, 99) < 8);
            jv = ($urandom_range(0, 99) < 25);
            jc = ($urandom_range(0, 1) == 1);
            rt = ($urandom_range(0, 99) < 25);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 9) != 0) a = a & ~32'h3;
            if ($urandom_range(0, 9) != 0) b = b & ~32'h3;
            cyc(r, s, t, rv, a, jv, b, jc, rt);
        end

        idle(1);
        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
